// File: rtl/cluster_link_pkg.sv
// Shared constants, header layout and helpers for the cluster link formatter.
// Clusters are {cnt[2:0], adr[10:0]}; adr >= MXPADS marks an empty slot.
package cluster_link_pkg;

   localparam int unsigned MXCLSTBITS = 14;
   localparam int unsigned MXCLUSTERS = 8;
   localparam int unsigned MXPADS     = 1536;
   localparam int unsigned ADRBITS    = 11;
   localparam int unsigned WORDBITS   = 16;
   localparam int unsigned FRAMEBITS  = 64;
   localparam logic [WORDBITS-1:0] IDLE_WORD = 16'hBCBC;

   // Header bit positions within the top byte of each 64-bit frame.
   localparam int unsigned HDR_MARK   = 7;
   localparam int unsigned HDR_BC0    = 6;
   localparam int unsigned HDR_RESYNC = 5;
   localparam int unsigned HDR_OVF    = 4;
   localparam int unsigned HDR_CNT_HI = 3;
   localparam int unsigned HDR_CNT_LO = 1;
   localparam int unsigned HDR_PAR    = 0;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_W0,
      PH_W1,
      PH_W2,
      PH_W3
   } phase_t;

   typedef struct packed {
      logic       bc0;
      logic       resync;
      logic       ovf;
      logic [2:0] cnt;
   } hdr_flags_t;

   function automatic logic cluster_valid(input logic [ADRBITS-1:0] adr);
      return 32'(adr) < MXPADS;
   endfunction

endpackage

// File: rtl/link_frame_serializer.sv
// Latches four clusters plus header flags on load, builds the parity-protected
// 64-bit frame and shifts it out as four 16-bit words, most significant first.
module link_frame_serializer
   import cluster_link_pkg::*;
(
   input  logic                      clock4x,
   input  logic                      global_reset,
   input  logic                      load,
   input  logic                      shift,
   input  logic [4*MXCLSTBITS-1:0]   clusters,
   input  hdr_flags_t                flags,
   output logic [WORDBITS-1:0]       data
);

   logic [7:0]               hdr;
   logic [FRAMEBITS-1:0]     frame;
   logic [FRAMEBITS-17:0]    rest;

   // NOTE: every combinational variable gets a default first so no latch is inferred.
   always_comb begin
      hdr                        = '0;
      hdr[HDR_MARK]              = 1'b1;
      hdr[HDR_BC0]               = flags.bc0;
      hdr[HDR_RESYNC]            = flags.resync;
      hdr[HDR_OVF]               = flags.ovf;
      hdr[HDR_CNT_HI:HDR_CNT_LO] = flags.cnt;
      // Parity bit makes the whole 64-bit frame carry an even number of ones.
      hdr[HDR_PAR]               = ^{hdr[7:1], clusters};
      frame                      = {hdr, clusters};
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clock4x) begin
      if (global_reset) begin
         data <= IDLE_WORD;
         rest <= '0;
      end else if (load) begin
         data <= frame[FRAMEBITS-1 -: WORDBITS];
         rest <= frame[FRAMEBITS-17:0];
      end else if (shift) begin
         data <= rest[FRAMEBITS-17 -: WORDBITS];
         rest <= {rest[FRAMEBITS-33:0], {WORDBITS{1'b0}}};
      end else begin
         data <= IDLE_WORD;
      end
   end

endmodule

// File: rtl/cluster_link_formatter.sv
// Frames the eight per-bx clusters into two 64-bit link packets and serializes
// them as 16-bit words; keeps frame, overflow and misalignment counters.
module cluster_link_formatter
   import cluster_link_pkg::*;
(
   input  logic                  clock4x,
   input  logic                  global_reset,
   input  logic                  bx_strobe,
   input  logic [MXCLSTBITS-1:0] cluster0,
   input  logic [MXCLSTBITS-1:0] cluster1,
   input  logic [MXCLSTBITS-1:0] cluster2,
   input  logic [MXCLSTBITS-1:0] cluster3,
   input  logic [MXCLSTBITS-1:0] cluster4,
   input  logic [MXCLSTBITS-1:0] cluster5,
   input  logic [MXCLSTBITS-1:0] cluster6,
   input  logic [MXCLSTBITS-1:0] cluster7,
   input  logic                  bc0,
   input  logic                  resync,
   output logic [WORDBITS-1:0]   link0_data,
   output logic [WORDBITS-1:0]   link1_data,
   output logic                  link_valid,
   output logic                  frame_start,
   output logic [15:0]           overflow_cnt,
   output logic [7:0]            misalign_cnt
);

   phase_t      phase_q;
   logic [2:0]  frame_cnt_q;
   logic [15:0] overflow_q;
   logic [7:0]  misalign_q;
   logic        ovf;
   logic        mid_frame;
   logic        shift;
   hdr_flags_t  flags;

   assign ovf       = cluster_valid(cluster7[ADRBITS-1:0]);
   assign mid_frame = (phase_q == PH_W0) || (phase_q == PH_W1);
   assign shift     = !bx_strobe &&
                      ((phase_q == PH_W0) || (phase_q == PH_W1) || (phase_q == PH_W2));

   // A resync frame is numbered 0 so the frame after it carries 1.
   assign flags = '{bc0: bc0, resync: resync, ovf: ovf,
                    cnt: resync ? 3'd0 : frame_cnt_q};

   always_ff @(posedge clock4x) begin
      if (global_reset) begin
         phase_q     <= PH_IDLE;
         frame_cnt_q <= '0;
         overflow_q  <= '0;
         misalign_q  <= '0;
         frame_start <= 1'b0;
         link_valid  <= 1'b0;
      end else begin
         frame_start <= bx_strobe;
         link_valid  <= bx_strobe || shift;
         if (bx_strobe) begin
            phase_q     <= PH_W0;
            frame_cnt_q <= resync ? 3'd1 : frame_cnt_q + 3'd1;
            if (ovf && overflow_q != 16'hFFFF)
               overflow_q <= overflow_q + 16'd1;
            if (mid_frame && misalign_q != 8'hFF)
               misalign_q <= misalign_q + 8'd1;
         end else begin
            case (phase_q)
               PH_W0:   phase_q <= PH_W1;
               PH_W1:   phase_q <= PH_W2;
               PH_W2:   phase_q <= PH_W3;
               default: phase_q <= PH_IDLE;
            endcase
         end
      end
   end

   assign overflow_cnt = overflow_q;
   assign misalign_cnt = misalign_q;

   link_frame_serializer u_link0 (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .load         (bx_strobe),
      .shift        (shift),
      .clusters     ({cluster3, cluster2, cluster1, cluster0}),
      .flags        (flags),
      .data         (link0_data)
   );

   link_frame_serializer u_link1 (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .load         (bx_strobe),
      .shift        (shift),
      .clusters     ({cluster7, cluster6, cluster5, cluster4}),
      .flags        (flags),
      .data         (link1_data)
   );

endmodule
